// File: rtl/pulpemu_clk_ctrl_pkg.sv
// Shared types and constants for the cluster clock-gating controller.
// Holds the FSM state encoding and the drain/wake counter width.
package pulpemu_clk_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } clk_state_e;

  // The cluster clock is off only in GATED; every other state keeps it running.
  function automatic logic enable_for(input clk_state_e st);
    return (st != ST_GATED);
  endfunction

endpackage

// File: rtl/pulpemu_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Adds two cycles of latency; the reset clears both stages.
module pulpemu_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic sync_in,
  output logic sync_out
);

  logic meta_r;
  logic sync_r;

  // Two back-to-back flops; the first stage may go metastable, the second resolves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= sync_in;
      sync_r <= meta_r;
    end
  end

  assign sync_out = sync_r;

endmodule

// File: rtl/pulpemu_cluster_clk_ctrl.sv
// Cluster clock-gating controller: drains the cluster after a gate request,
// holds the clock off, and restores it on a wake event or request withdrawal.
module pulpemu_cluster_clk_ctrl #(
  parameter int DRAIN_CYCLES = 8,
  parameter int WAKE_CYCLES  = 4
) (
  input  logic       pulp_cluster_clk,
  input  logic       pulp_soc_rst,
  input  logic       gate_req_i,
  input  logic       cluster_busy_i,
  input  logic       wake_evt_async_i,
  output logic       pulp_cluster_clk_enable,
  output logic       gated_o,
  output logic [1:0] state_o
);

  import pulpemu_clk_ctrl_pkg::*;

  if ((DRAIN_CYCLES < 1) || (DRAIN_CYCLES > 256)) begin : g_bad_drain
    $error("pulpemu_cluster_clk_ctrl: DRAIN_CYCLES must be in 1..256");
  end
  if ((WAKE_CYCLES < 1) || (WAKE_CYCLES > 256)) begin : g_bad_wake
    $error("pulpemu_cluster_clk_ctrl: WAKE_CYCLES must be in 1..256");
  end

  // The counter counts down to zero, so the loaded value is one less than the cycle count.
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);

  clk_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             enable_r;
  logic             gated_r;
  logic             wake_s;
  logic             drain_abort_s;
  logic             gate_ok_s;

  pulpemu_sync_2ff u_wake_sync (
    .clk      (pulp_cluster_clk),
    .rst      (pulp_soc_rst),
    .sync_in  (wake_evt_async_i),
    .sync_out (wake_s)
  );

  // A pending wake always beats a gate request, both when entering and while draining.
  assign gate_ok_s     = gate_req_i & ~cluster_busy_i & ~wake_s;
  assign drain_abort_s = ~gate_ok_s;

  // State, counter and outputs update together so the outputs never lag the state.
  always_ff @(posedge pulp_cluster_clk or posedge pulp_soc_rst) begin
    if (pulp_soc_rst) begin
      state_r  <= ST_RUN;
      cnt_r    <= {CNT_W{1'b0}};
      enable_r <= 1'b1;
      gated_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (gate_ok_s) begin
            state_r  <= ST_DRAIN;
            cnt_r    <= DRAIN_LOAD;
            enable_r <= enable_for(ST_DRAIN);
            gated_r  <= 1'b0;
          end else begin
            state_r  <= ST_RUN;
            cnt_r    <= cnt_r;
            enable_r <= enable_for(ST_RUN);
            gated_r  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_abort_s) begin
            state_r  <= ST_RUN;
            cnt_r    <= {CNT_W{1'b0}};
            enable_r <= enable_for(ST_RUN);
            gated_r  <= 1'b0;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            state_r  <= ST_GATED;
            cnt_r    <= {CNT_W{1'b0}};
            enable_r <= enable_for(ST_GATED);
            gated_r  <= 1'b1;
          end else begin
            state_r  <= ST_DRAIN;
            cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            enable_r <= enable_for(ST_DRAIN);
            gated_r  <= 1'b0;
          end
        end
        ST_GATED: begin
          if (wake_s || !gate_req_i) begin
            state_r  <= ST_WAKE;
            cnt_r    <= WAKE_LOAD;
            enable_r <= enable_for(ST_WAKE);
            gated_r  <= 1'b0;
          end else begin
            state_r  <= ST_GATED;
            cnt_r    <= cnt_r;
            enable_r <= enable_for(ST_GATED);
            gated_r  <= 1'b1;
          end
        end
        ST_WAKE: begin
          // Requests and busy are deliberately ignored until the wake window completes.
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r  <= ST_RUN;
            cnt_r    <= {CNT_W{1'b0}};
            enable_r <= enable_for(ST_RUN);
            gated_r  <= 1'b0;
          end else begin
            state_r  <= ST_WAKE;
            cnt_r    <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            enable_r <= enable_for(ST_WAKE);
            gated_r  <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_RUN;
          cnt_r    <= {CNT_W{1'b0}};
          enable_r <= 1'b1;
          gated_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pulp_cluster_clk_enable = enable_r;
  assign gated_o                 = gated_r;
  assign state_o                 = state_r;

endmodule
